// File: rtl/red_pitaya_ext_clk_supervisor.sv
// External reference clock supervisor: measures ext_clk_i against clk over a fixed gate,
// then sequences the downstream PLL reset and watches its lock, flagging sticky faults.
`timescale 1ns/1ps
module red_pitaya_ext_clk_supervisor #(
    parameter int GATE_CYCLES  = 125000,
    parameter int EXP_EDGES    = 10000,
    parameter int TOL          = 20,
    parameter int RST_CYCLES   = 64,
    parameter int LOCK_HOLD    = 1024,
    parameter int LOCK_TIMEOUT = 250000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ext_clk_i,
    input  logic        pll_locked_i,
    input  logic        enable_i,
    input  logic        fault_clr_i,
    output logic        pll_rstn_o,
    output logic        ref_ok_o,
    output logic        locked_o,
    output logic        fault_o,
    output logic [2:0]  state_o,
    output logic [15:0] edge_cnt_o
);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int HW = $clog2(LOCK_HOLD + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEASURE   = 3'd1,
        ST_PLL_RST   = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]        async_in;
    logic [1:0]        sync_bit;
    logic              ext_prev_reg;
    logic [GW-1:0]     gate_cnt_reg;
    logic [15:0]       edge_cnt_reg;
    logic [RW-1:0]     rst_cnt_reg;
    logic [HW-1:0]     hold_cnt_reg;
    logic [TW-1:0]     timeout_cnt_reg;
    logic              pll_rstn_reg, ref_ok_reg, locked_reg, fault_reg;
    logic [15:0]       edge_cnt_out_reg;

    logic              ext_sync, lock_sync, ext_edge, gating, window_end, in_tol, fault_set;
    logic [15:0]       cnt_final;
    logic signed [31:0] deviation;

    // bit 0: ext reference, bit 1: PLL lock
    assign async_in = {pll_locked_i, ext_clk_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_reg, sync_reg;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= async_in[gi];
                sync_reg <= meta_reg;
            end
        end
        assign sync_bit[gi] = sync_reg;
    end

    assign ext_sync  = sync_bit[0];
    assign lock_sync = sync_bit[1];
    assign ext_edge  = ext_sync & ~ext_prev_reg;

    assign gating     = (state_reg == ST_MEASURE) || (state_reg == ST_WAIT_LOCK) || (state_reg == ST_RUN);
    assign window_end = gating && enable_i && (gate_cnt_reg == GW'(GATE_CYCLES - 1));
    // an edge on the final gate cycle still belongs to the closing window
    assign cnt_final  = (&edge_cnt_reg) ? edge_cnt_reg : edge_cnt_reg + 16'(ext_edge);
    assign deviation  = $signed({16'd0, cnt_final}) - EXP_EDGES;
    assign in_tol     = (deviation <= TOL) && (deviation >= -TOL);

    always_comb begin
        state_next = state_reg;
        fault_set  = 1'b0;
        if (!enable_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:    state_next = ST_MEASURE;
                ST_MEASURE: if (window_end && in_tol) state_next = ST_PLL_RST;
                ST_PLL_RST: if (rst_cnt_reg == RW'(RST_CYCLES - 1)) state_next = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_sync && (hold_cnt_reg == HW'(LOCK_HOLD - 1))) begin
                        state_next = ST_RUN;
                    end else if (timeout_cnt_reg == TW'(LOCK_TIMEOUT - 1)) begin
                        fault_set  = 1'b1;
                        state_next = ST_PLL_RST;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync) begin
                        fault_set  = 1'b1;
                        state_next = ST_PLL_RST;
                    end else if (window_end && !in_tol) begin
                        fault_set  = 1'b1;
                        state_next = ST_MEASURE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= ST_IDLE;
            ext_prev_reg     <= 1'b0;
            gate_cnt_reg     <= '0;
            edge_cnt_reg     <= '0;
            rst_cnt_reg      <= '0;
            hold_cnt_reg     <= '0;
            timeout_cnt_reg  <= '0;
            pll_rstn_reg     <= 1'b0;
            ref_ok_reg       <= 1'b0;
            locked_reg       <= 1'b0;
            fault_reg        <= 1'b0;
            edge_cnt_out_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ext_prev_reg <= ext_sync;

            if (!gating || window_end) begin
                gate_cnt_reg <= '0;
                edge_cnt_reg <= '0;
            end else begin
                gate_cnt_reg <= gate_cnt_reg + 1'b1;
                edge_cnt_reg <= cnt_final;
            end

            if (window_end) begin
                edge_cnt_out_reg <= cnt_final;
                ref_ok_reg       <= in_tol;
            end
            if (!enable_i) ref_ok_reg <= 1'b0;

            rst_cnt_reg <= (state_reg == ST_PLL_RST && state_next == ST_PLL_RST) ?
                           rst_cnt_reg + 1'b1 : '0;
            hold_cnt_reg <= (state_reg == ST_WAIT_LOCK && state_next == ST_WAIT_LOCK && lock_sync) ?
                            hold_cnt_reg + 1'b1 : '0;
            timeout_cnt_reg <= (state_reg == ST_WAIT_LOCK && state_next == ST_WAIT_LOCK) ?
                               timeout_cnt_reg + 1'b1 : '0;

            pll_rstn_reg <= (state_next == ST_WAIT_LOCK) || (state_next == ST_RUN);
            locked_reg   <= (state_next == ST_RUN);

            if (fault_set)        fault_reg <= 1'b1;
            else if (fault_clr_i) fault_reg <= 1'b0;
        end
    end

    assign state_o    = state_reg;
    assign pll_rstn_o = pll_rstn_reg;
    assign ref_ok_o   = ref_ok_reg;
    assign locked_o   = locked_reg;
    assign fault_o    = fault_reg;
    assign edge_cnt_o = edge_cnt_out_reg;
endmodule
